sequenciador_notas: RTL and testbench

SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

---
 rtl/sequenciador_notas_pkg.sv | 21 ++
 rtl/sequenciador_notas_if.sv | 37 +++
 rtl/sequenciador_notas_contador_tempo.sv | 27 ++
 rtl/sequenciador_notas.sv | 141 ++++++++++++++
 tb/tb_sequenciador_notas.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sequenciador_notas_pkg.sv
// Shared definitions for the melody sequencer: FSM state encoding, silence code and bus widths.
package sinfonia_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned NOTA_W  = 7;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] OCIOSO   = 3'd0;
  localparam logic [STATE_W-1:0] ENDERECA = 3'd1;
  localparam logic [STATE_W-1:0] TOCA     = 3'd2;
  localparam logic [STATE_W-1:0] PAUSA    = 3'd3;
  localparam logic [STATE_W-1:0] FIM      = 3'd4;

  localparam logic [CODE_W-1:0] NOTA_SILENCIO = 3'b000;

  typedef logic [ADDR_W-1:0] endereco_t;
  typedef logic [NOTA_W-1:0] nota_t;
  typedef logic [CODE_W-1:0] codigo_t;

endpackage

// File: rtl/sequenciador_notas_if.sv
// Control, melody-memory and Arduino signals of the sequencer.
// The abortar line exists only when SEQUENCIADOR_ABORTAR_EN is defined.
interface sequenciador_notas_if;
  import sinfonia_pkg::*;

  logic      iniciar;
  endereco_t limite;
  endereco_t endereco;
  nota_t     nota;
  codigo_t   arduino_out;
  logic      ocupado;
  logic      pronto;
`ifdef SEQUENCIADOR_ABORTAR_EN
  logic      abortar;

  modport master (
    output iniciar, limite, nota, abortar,
    input  endereco, arduino_out, ocupado, pronto
  );

  modport slave (
    input  iniciar, limite, nota, abortar,
    output endereco, arduino_out, ocupado, pronto
  );
`else
  modport master (
    output iniciar, limite, nota,
    input  endereco, arduino_out, ocupado, pronto
  );

  modport slave (
    input  iniciar, limite, nota,
    output endereco, arduino_out, ocupado, pronto
  );
`endif

endinterface

// File: rtl/sequenciador_notas_contador_tempo.sv
// Duration timer: counts while conta is high, clears on zera; fim flags the last counted cycle.
module contador_tempo #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] duracao,
  output logic [W-1:0] contagem,
  output logic         fim
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + W'(1);
    end
  end

  // Combinational so the FSM can leave the state on the very cycle the duration expires.
  assign fim = conta && (contagem == (duracao - W'(1)));

endmodule

// File: rtl/sequenciador_notas.sv
// Plays a melody stored in an external memory: one note per address, each held then followed by silence.
// Optional abort input enabled by defining SEQUENCIADOR_ABORTAR_EN.
module sequenciador_notas
  import sinfonia_pkg::*;
#(
  parameter int unsigned T_NOTA  = 25000000,
  parameter int unsigned T_PAUSA = 5000000
) (
  input logic                  clock,
  input logic                  reset,
  sequenciador_notas_if.slave  bus
);

  localparam int unsigned T_MAX   = (T_NOTA > T_PAUSA) ? T_NOTA : T_PAUSA;
  localparam int unsigned TIMER_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
  localparam logic [TIMER_W-1:0] DUR_NOTA  = TIMER_W'(T_NOTA);
  localparam logic [TIMER_W-1:0] DUR_PAUSA = TIMER_W'(T_PAUSA);

  logic [STATE_W-1:0] state_q, state_d;
  endereco_t          endereco_q, endereco_d;
  endereco_t          limite_q, limite_d;
  codigo_t            saida_q, saida_d;
  logic               pronto_q, pronto_d;
  logic               ocupado_q, ocupado_d;

  logic               zera, conta, fim;
  logic [TIMER_W-1:0] duracao, contagem;
  codigo_t            codigo_c;

  contador_tempo #(
    .W (TIMER_W)
  ) u_contador_tempo (
    .clock    (clock),
    .reset    (reset),
    .zera     (zera),
    .conta    (conta),
    .duracao  (duracao),
    .contagem (contagem),
    .fim      (fim)
  );

  // One-hot to note code; iterating downwards lets the lowest set bit win.
  always_comb begin
    codigo_c = NOTA_SILENCIO;
    for (int i = int'(NOTA_W) - 1; i >= 0; i--) begin
      if (bus.nota[i]) begin
        codigo_c = CODE_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    saida_d    = NOTA_SILENCIO;
    pronto_d   = 1'b0;
    conta      = 1'b0;
    zera       = 1'b1;
    duracao    = DUR_PAUSA;

    case (state_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          limite_d   = bus.limite;
          endereco_d = '0;
          state_d    = ENDERECA;
        end
      end
      ENDERECA: begin
        state_d = TOCA;
      end
      TOCA: begin
        conta   = 1'b1;
        zera    = fim;
        duracao = DUR_NOTA;
        // Memory data settles during the first TOCA cycle; capture once, then hold.
        saida_d = (contagem == '0) ? codigo_c : saida_q;
        if (fim) begin
          state_d = PAUSA;
        end
      end
      PAUSA: begin
        conta = 1'b1;
        zera  = fim;
        if (fim) begin
          if (endereco_q == limite_q) begin
            state_d = FIM;
          end else begin
            endereco_d = endereco_q + ADDR_W'(1);
            state_d    = ENDERECA;
          end
        end
      end
      FIM: begin
        pronto_d = 1'b1;
        state_d  = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase

`ifdef SEQUENCIADOR_ABORTAR_EN
    // Abort overrides every other transition; the address is kept for inspection.
    if (bus.abortar && (state_q != OCIOSO)) begin
      state_d  = OCIOSO;
      saida_d  = NOTA_SILENCIO;
      pronto_d = 1'b0;
      zera     = 1'b1;
      conta    = 1'b0;
    end
`endif

    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= OCIOSO;
      endereco_q <= '0;
      limite_q   <= '0;
      saida_q    <= NOTA_SILENCIO;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      saida_q    <= saida_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.endereco    = endereco_q;
  assign bus.arduino_out = saida_q;
  assign bus.pronto      = pronto_q;
  assign bus.ocupado     = ocupado_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Self-checking bench for sequenciador_notas with T_NOTA=4, T_PAUSA=2 against a cycle-timeline model.
module tb_sequenciador_notas;
  import sinfonia_pkg::*;

  localparam int unsigned TN  = 4;
  localparam int unsigned TP  = 2;
  localparam int unsigned PER = 1 + TN + TP;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  sequenciador_notas_if bus ();

  sequenciador_notas #(
    .T_NOTA  (TN),
    .T_PAUSA (TP)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous melody memory: data follows the address one clock later.
  always @(posedge clk) bus.nota <= mem[bus.endereco];

  function automatic logic [2:0] ref_code(input logic [6:0] v);
    for (int b = 0; b < 7; b++) begin
      if (v[b]) return 3'(b + 1);
    end
    return 3'b000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: iniciar pulsed; 1: iniciar/limite noise while busy; 2: iniciar held high throughout.
  task automatic run_melody(input int lim, input int mode);
    int n, last, j, nn, r;
    logic [2:0] codes [16];
    logic [2:0] eo;
    n    = lim + 1;
    last = int'(PER) * n + 1;
    for (int i = 0; i < 16; i++) codes[i] = ref_code(mem[i]);
    bus.limite  = 4'(lim);
    bus.iniciar = 1'b1;
    step();
    for (int k = 0; k <= last; k++) begin
      eo = 3'b000;
      if (k >= 1) begin
        j  = k - 1;
        nn = j / int'(PER);
        r  = j % int'(PER);
        if (nn < n && r >= 1 && r <= int'(TN)) eo = codes[nn];
      end
      chk("arduino_out", 32'(bus.arduino_out), 32'(eo));
      chk("ocupado", 32'(bus.ocupado), 32'(k <= int'(PER) * n));
      chk("pronto", 32'(bus.pronto), 32'(k == last));
      chk("endereco", 32'(bus.endereco), 32'(((k / int'(PER)) < n - 1) ? (k / int'(PER)) : n - 1));
      if (mode == 2) begin
        bus.iniciar = 1'b1;
      end else if (mode == 1 && k < last) begin
        bus.iniciar = 1'($urandom_range(0, 1));
        bus.limite  = 4'($urandom);
      end else begin
        bus.iniciar = 1'b0;
      end
      if (k < last) step();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) mem[i] = 7'(1 << $urandom_range(0, 6));
      else mem[i] = 7'($urandom);
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.iniciar = 1'b0;
    bus.limite  = '0;
`ifdef SEQUENCIADOR_ABORTAR_EN
    bus.abortar = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    step();
    step();
    chk("rst_arduino_out", 32'(bus.arduino_out), 32'(0));
    chk("rst_ocupado", 32'(bus.ocupado), 32'(0));
    chk("rst_pronto", 32'(bus.pronto), 32'(0));
    chk("rst_endereco", 32'(bus.endereco), 32'(0));
    rst = 1'b1;
    step();
    chk("idle_ocupado", 32'(bus.ocupado), 32'(0));

    // Test 1: three one-hot notes, limite=2
    mem[0] = 7'b0000001;
    mem[1] = 7'b0000100;
    mem[2] = 7'b1000000;
    run_melody(2, 0);

    // Test 2: single note
    mem[0] = 7'b0000010;
    run_melody(0, 0);

    // Test 3: silent note and multi-hot note
    mem[0] = 7'b0000000;
    mem[1] = 7'b0001100;
    run_melody(1, 0);

    // Test 4: iniciar held high; restart only once back in OCIOSO
    fill_random();
    run_melody(2, 2);
    step();
    chk("restart_ocupado", 32'(bus.ocupado), 32'(1));
    chk("restart_endereco", 32'(bus.endereco), 32'(0));
    chk("restart_pronto", 32'(bus.pronto), 32'(0));
    chk("restart_arduino_out", 32'(bus.arduino_out), 32'(0));
    bus.iniciar = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Test 5: reset during the second note
    fill_random();
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    chk("t5_second_note", 32'(bus.arduino_out), 32'(ref_code(mem[1])));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_arduino_out", 32'(bus.arduino_out), 32'(0));
    chk("t5_ocupado", 32'(bus.ocupado), 32'(0));
    chk("t5_endereco", 32'(bus.endereco), 32'(0));
    chk("t5_pronto", 32'(bus.pronto), 32'(0));
    for (int k = 0; k < 30; k++) begin
      step();
      chk("t5_no_pronto", 32'(bus.pronto), 32'(0));
      chk("t5_idle", 32'(bus.ocupado), 32'(0));
    end

    // Randomized melodies, including the 16-note boundary
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_melody((t == 0) ? 15 : int'($urandom_range(0, 15)), 1);
    end

`ifdef SEQUENCIADOR_ABORTAR_EN
    // Test 6: abort in the pause after note 1
    fill_random();
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    for (int k = 1; k <= 12; k++) step();
    bus.abortar = 1'b1;
    step();
    bus.abortar = 1'b0;
    chk("t6_ocupado", 32'(bus.ocupado), 32'(0));
    chk("t6_arduino_out", 32'(bus.arduino_out), 32'(0));
    chk("t6_endereco", 32'(bus.endereco), 32'(1));
    chk("t6_pronto", 32'(bus.pronto), 32'(0));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t6_no_pronto", 32'(bus.pronto), 32'(0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
